// File: rtl/decode_stage.sv
// Single-issue instruction decode stage: registered decode bundle behind a valid/ready
// handshake, a per-register pending-write scoreboard and a saturating illegal-opcode counter.
module decode_stage #(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3,
  parameter int IMM_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        instruction,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                alu_op,
  output logic                      reg_write_enable,
  output logic [REG_AW-1:0]         dest_reg_sel,
  output logic [REG_AW-1:0]         src_reg1_sel,
  output logic [REG_AW-1:0]         src_reg2_sel,
  output logic                      load_immediate,
  output logic [IMM_W-1:0]          immediate_data,
  output logic                      illegal,
  input  logic                      wb_valid,
  input  logic [REG_AW-1:0]         wb_reg,
  output logic [(2**REG_AW)-1:0]    pending,
  output logic [CNT_W-1:0]          illegal_count,
  input  logic                      count_clear
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam int DEST_MSB = INSTR_W - 4;
  localparam int SRC1_MSB = DEST_MSB - REG_AW;
  localparam int SRC2_MSB = SRC1_MSB - REG_AW;

  typedef struct packed {
    logic [2:0]        alu_op;
    logic              we;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              ldi;
    logic [IMM_W-1:0]  imm;
    logic              ill;
  } bundle_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [2:0]        opcode;
  logic [REG_AW-1:0] f_dest, f_src1, f_src2;
  logic [IMM_W-1:0]  f_imm;
  bundle_t           dec;
  logic              writes, uses_src1, uses_src2, hazard, accept;

  bundle_t             bundle_q, bundle_d;
  logic                out_valid_q, out_valid_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    illegal_count_q, illegal_count_d;

  assign opcode = instruction[INSTR_W-1 -: 3];
  assign f_dest = instruction[DEST_MSB -: REG_AW];
  assign f_src1 = instruction[SRC1_MSB -: REG_AW];
  assign f_src2 = instruction[SRC2_MSB -: REG_AW];
  assign f_imm  = instruction[IMM_W-1:0];

  always_comb begin
    dec = '0;
    case (opcode)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        dec.alu_op = opcode;
        dec.we     = 1'b1;
        dec.dest   = f_dest;
        dec.src1   = f_src1;
        dec.src2   = f_src2;
      end
      3'b100: begin
        dec.alu_op = 3'b100;
        dec.we     = 1'b1;
        dec.dest   = f_dest;
        dec.src1   = f_src1;
      end
      3'b101: begin
        dec.ldi  = 1'b1;
        dec.we   = 1'b1;
        dec.dest = f_dest;
        dec.imm  = f_imm;
      end
      default: dec.ill = 1'b1;
    endcase
  end

  // Hazard looks only at the registered scoreboard, so a writeback this cycle cannot release it.
  assign writes    = (opcode <= 3'b101);
  assign uses_src1 = (opcode <= 3'b100);
  assign uses_src2 = (opcode <= 3'b011);
  assign hazard    = in_valid && ((writes    && pending_q[f_dest]) ||
                                  (uses_src1 && pending_q[f_src1]) ||
                                  (uses_src2 && pending_q[f_src2]));
  assign in_ready  = (!out_valid_q || out_ready) && !hazard;
  assign accept    = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      bundle_d    = '0;
    end

    // Clear first so a same-cycle set on the same register wins.
    pending_d = pending_q;
    if (wb_valid)
      pending_d[wb_reg] = 1'b0;
    if (accept && dec.we)
      pending_d[dec.dest] = 1'b1;

    illegal_count_d = illegal_count_q;
    if (count_clear)
      illegal_count_d = '0;
    else if (accept && dec.ill)
      illegal_count_d = sat_inc(illegal_count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      bundle_q        <= '0;
      pending_q       <= '0;
      illegal_count_q <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      bundle_q        <= bundle_d;
      pending_q       <= pending_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign alu_op           = bundle_q.alu_op;
  assign reg_write_enable = bundle_q.we;
  assign dest_reg_sel     = bundle_q.dest;
  assign src_reg1_sel     = bundle_q.src1;
  assign src_reg2_sel     = bundle_q.src2;
  assign load_immediate   = bundle_q.ldi;
  assign immediate_data   = bundle_q.imm;
  assign illegal          = bundle_q.ill;
  assign pending          = pending_q;
  assign illegal_count    = illegal_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, hazards, scoreboard, illegal counting and reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, wb_valid, count_clear;
  logic [15:0] instruction;
  logic [2:0]  wb_reg;
  logic        in_ready, out_valid, reg_write_enable, load_immediate, illegal;
  logic [2:0]  alu_op, dest_reg_sel, src_reg1_sel, src_reg2_sel;
  logic [7:0]  immediate_data, pending, illegal_count;

  logic        in_valid2;
  logic [15:0] instruction2;
  logic        in_ready2, out_valid2, we2, ldi2, ill2;
  logic [2:0]  alu2, dest2, s1_2, s2_2;
  logic [7:0]  imm2, pend2;
  logic [1:0]  cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage #(.INSTR_W(16), .REG_AW(3), .IMM_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .reg_write_enable(reg_write_enable), .dest_reg_sel(dest_reg_sel),
    .src_reg1_sel(src_reg1_sel), .src_reg2_sel(src_reg2_sel),
    .load_immediate(load_immediate), .immediate_data(immediate_data), .illegal(illegal),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .pending(pending),
    .illegal_count(illegal_count), .count_clear(count_clear)
  );

  decode_stage #(.INSTR_W(16), .REG_AW(3), .IMM_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .instruction(instruction2), .out_valid(out_valid2), .out_ready(1'b1),
    .alu_op(alu2), .reg_write_enable(we2), .dest_reg_sel(dest2),
    .src_reg1_sel(s1_2), .src_reg2_sel(s2_2),
    .load_immediate(ldi2), .immediate_data(imm2), .illegal(ill2),
    .wb_valid(1'b0), .wb_reg(3'd0), .pending(pend2),
    .illegal_count(cnt2), .count_clear(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; count_clear = 1'b0;
    instruction = 16'h0000; wb_reg = 3'd0; in_valid2 = 1'b0; instruction2 = 16'h0000;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_count", illegal_count, 0);
    rst_n = 1'b1;

    // Flow: ADD r1,r2,r3
    in_valid = 1'b1; instruction = 16'h0530;
    check("flow_in_ready", in_ready, 1);
    tick();
    check("flow_out_valid", out_valid, 1);
    check("flow_alu_op", alu_op, 3'b000);
    check("flow_dest", dest_reg_sel, 1);
    check("flow_src1", src_reg1_sel, 2);
    check("flow_src2", src_reg2_sel, 3);
    check("flow_we", reg_write_enable, 1);
    check("flow_imm", immediate_data, 0);
    check("flow_pending", pending, 8'h02);
    in_valid = 1'b0; wb_valid = 1'b1; wb_reg = 3'd1;
    tick();
    check("flow_drain_valid", out_valid, 0);
    check("flow_wb_pending", pending, 8'h00);
    wb_valid = 1'b0;

    // LDI r2,0x5A then dependent ADD r3,r2,r2
    in_valid = 1'b1; instruction = 16'hA85A;
    tick();
    check("ldi_out_valid", out_valid, 1);
    check("ldi_load_imm", load_immediate, 1);
    check("ldi_imm", immediate_data, 8'h5A);
    check("ldi_dest", dest_reg_sel, 2);
    check("ldi_alu_op", alu_op, 0);
    check("ldi_src1", src_reg1_sel, 0);
    check("ldi_pending", pending, 8'h04);
    instruction = 16'h0D20;
    check("haz_in_ready0", in_ready, 0);
    tick();
    check("haz_out_valid0", out_valid, 0);
    wb_valid = 1'b1; wb_reg = 3'd2;
    check("haz_no_bypass", in_ready, 0);
    tick();
    check("haz_wb_pending", pending, 8'h00);
    check("haz_not_taken", out_valid, 0);
    wb_valid = 1'b0;
    check("haz_released", in_ready, 1);
    tick();
    check("add_out_valid", out_valid, 1);
    check("add_dest", dest_reg_sel, 3);
    check("add_src1", src_reg1_sel, 2);
    check("add_src2", src_reg2_sel, 2);
    check("add_ldi", load_immediate, 0);
    check("add_pending", pending, 8'h08);
    in_valid = 1'b0; wb_valid = 1'b1; wb_reg = 3'd3;
    tick();
    check("add_wb_pending", pending, 8'h00);
    wb_valid = 1'b0;

    // Backpressure with ADD r1,r2,r3 in flight
    in_valid = 1'b1; instruction = 16'h0530; out_ready = 1'b0;
    tick();
    check("bp_accept", out_valid, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_dest", dest_reg_sel, 1);
      check("bp_hold_src1", src_reg1_sel, 2);
      check("bp_hold_src2", src_reg2_sel, 3);
      check("bp_hold_we", reg_write_enable, 1);
    end
    out_ready = 1'b1; wb_valid = 1'b1; wb_reg = 3'd1;
    tick();
    check("bp_complete", out_valid, 0);
    check("bp_pending", pending, 8'h00);

    // Same-cycle set and clear on r1: set wins
    in_valid = 1'b1; instruction = 16'h0530;
    tick();
    check("setwins_pending", pending, 8'h02);
    wb_valid = 1'b0;
    // NOT r4,r5 with nonzero src2/imm fields that must be zeroed
    instruction = 16'h92F0;
    tick();
    check("not_alu_op", alu_op, 3'b100);
    check("not_dest", dest_reg_sel, 4);
    check("not_src1", src_reg1_sel, 5);
    check("not_src2", src_reg2_sel, 0);
    check("not_imm", immediate_data, 0);
    check("not_pending", pending, 8'h12);
    in_valid = 1'b0; wb_valid = 1'b1; wb_reg = 3'd6;
    tick();
    check("wb_idle_reg", pending, 8'h12);
    wb_reg = 3'd1;
    tick();
    wb_reg = 3'd4;
    tick();
    check("clean_pending", pending, 8'h00);
    wb_valid = 1'b0;

    // Illegal opcodes, back to back
    in_valid = 1'b1; instruction = 16'hE000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("ill_valid", out_valid, 1);
      check("ill_flag", illegal, 1);
      check("ill_we", reg_write_enable, 0);
      check("ill_count", illegal_count, i);
    end
    instruction = 16'hDFFF; count_clear = 1'b1;
    tick();
    check("ill_clear_count", illegal_count, 0);
    check("ill_flag4", illegal, 1);
    check("ill_zero_dest", dest_reg_sel, 0);
    check("ill_zero_alu", alu_op, 0);
    check("ill_zero_imm", immediate_data, 0);
    check("ill_pending", pending, 8'h00);
    in_valid = 1'b0; count_clear = 1'b0;
    tick();

    // Saturation on the 2-bit counter instance
    in_valid2 = 1'b1; instruction2 = 16'hE000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sat_count", cnt2, (i < 3) ? i : 3);
    end
    in_valid2 = 1'b0;
    check("sat_final", cnt2, 2'd3);

    // Reset while a bundle is held and pending=0x06
    in_valid = 1'b1; instruction = 16'hE000;
    tick();
    instruction = 16'hA85A;
    tick();
    instruction = 16'h8400;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_pending", pending, 8'h06);
    check("pre_rst_count", illegal_count, 1);
    check("pre_rst_dest", dest_reg_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_pending", pending, 0);
    check("async_rst_count", illegal_count, 0);
    check("async_rst_dest", dest_reg_sel, 0);
    check("async_rst_alu", alu_op, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; instruction = 16'h0530;
    check("post_rst_valid0", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    tick();
    check("post_rst_valid1", out_valid, 1);
    check("post_rst_dest", dest_reg_sel, 1);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- INSTR_W, 16, instruction width.
- REG_AW, 3, register-select width; NUM_REGS = 2**REG_AW.
- IMM_W, 8, immediate width.
- CNT_W, 8, illegal-counter width.
REQ-002 SHALL derive the instruction fields from the parameters, MSB first, with no gaps between fields:
- opcode: 3 bits starting at bit INSTR_W-1.
- dest: REG_AW bits.
- src1: REG_AW bits.
- src2: REG_AW bits.
- imm: bits [IMM_W-1:0].
- Legal parameter sets require 3+3*REG_AW <= INSTR_W and IMM_W <= INSTR_W-3-REG_AW.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-004 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, instruction offered.
- in_ready, out, 1, instruction accepted when in_valid && in_ready.
- instruction, in, INSTR_W, encoded instruction.
- out_valid, out, 1, decoded bundle valid.
- out_ready, in, 1, downstream takes bundle when out_valid && out_ready.
- alu_op, out, 3, ALU operation.
- reg_write_enable, out, 1, destination write.
- dest_reg_sel, out, REG_AW, destination register.
- src_reg1_sel, out, REG_AW, source register 1.
- src_reg2_sel, out, REG_AW, source register 2.
- load_immediate, out, 1, load-immediate operation.
- immediate_data, out, IMM_W, immediate value.
- illegal, out, 1, bundle carries an undefined opcode.
- wb_valid, in, 1, writeback completes.
- wb_reg, in, REG_AW, register written back.
- pending, out, NUM_REGS, scoreboard of outstanding writes.
- illegal_count, out, CNT_W, saturating count of illegal instructions.
- count_clear, in, 1, synchronous clear of illegal_count.

Function
REQ-005 SHALL register all decoded outputs: a bundle accepted in cycle N appears with out_valid=1 in cycle N+1 (latency 1).
REQ-006 SHALL hold out_valid and all bundle outputs stable while out_valid && !out_ready.
REQ-007 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, giving a zero-bubble flow when there is no stall.
REQ-008 SHALL decode opcodes as follows:
- 000 ADD, 001 SUB, 010 AND, 011 OR: alu_op = opcode; write enabled; dest, src1 and src2 from their fields.
- 100 NOT: alu_op=100; write enabled; dest and src1 from their fields; src2=0.
- 101 LDI: load_immediate=1; write enabled; dest from its field; immediate_data = imm; alu_op=0; src1=src2=0.
REQ-009 SHALL decode opcodes 110 and 111 as illegal:
- illegal=1; reg_write_enable=0; all selects, alu_op and immediate_data = 0.
- The bundle is still forwarded with out_valid=1.
REQ-010 SHALL drive 0 on every unused output field; no X values on any output.
REQ-011 SHALL drive immediate_data=0 for every bundle other than LDI.
REQ-012 SHALL assert hazard when in_valid is high and any of the following pending bits is set:
- pending[dest] for a writing opcode;
- pending[src1] for opcodes 000-100;
- pending[src2] for opcodes 000-011.
REQ-013 SHALL evaluate hazard against the pending value registered at the start of the cycle; a same-cycle writeback does not release a stall (no bypass).
REQ-014 SHALL set pending[dest] on acceptance of any write-enabled instruction.
REQ-015 SHALL clear pending[wb_reg] on wb_valid.
REQ-016 SHALL let set win when a set and a clear target the same register in the same cycle.
REQ-017 SHALL ignore wb_valid for a register whose pending bit is already 0.
REQ-018 SHALL increment illegal_count by 1 on acceptance of an illegal instruction, saturating at 2**CNT_W-1.
REQ-019 SHALL zero illegal_count on count_clear; count_clear wins over a simultaneous increment.
REQ-020 SHALL ignore the instruction input whenever in_valid=0.

Reset
REQ-021 SHALL, while rst_n=0:
- hold out_valid=0 and all bundle outputs=0;
- hold pending=0 and illegal_count=0;
- take effect immediately, without waiting for a clock edge.
REQ-022 SHALL discard any in-flight bundle on a reset asserted mid-operation; the first accept after rst_n rises produces out_valid exactly one cycle later.

Verification
REQ-023 SHALL use INSTR_W=16, REG_AW=3, IMM_W=8 in the bench, giving fields opcode[15:13], dest[12:10], src1[9:7], src2[6:4], imm[7:0].
REQ-024 Bench SHALL cover the following directed scenarios:
- Flow: ADD r1,r2,r3 (0x0530) with out_ready=1 -> next cycle out_valid=1, alu_op=000, dest=1, src1=2, src2=3, reg_write_enable=1; pending=0x02.
- LDI r2,0x5A (0xA85A) followed by ADD r3,r2,r2 (0x0D20) -> LDI bundle has load_immediate=1, immediate_data=0x5A; ADD held with in_ready=0 until the cycle after wb_valid=1, wb_reg=2; then ADD is accepted and pending=0x08.
- Backpressure: out_ready=0 for 3 cycles with 0x0530 in flight -> bundle outputs unchanged, in_ready=0; the bundle completes on the first cycle with out_ready=1.
- Illegal: 0xE000 accepted 3 times -> illegal=1, reg_write_enable=0, illegal_count=3; count_clear together with a fourth illegal accept -> illegal_count=0.
- Saturation: CNT_W=2 with 5 illegal accepts -> illegal_count=3.
- Reset: rst_n low while out_valid=1 and pending=0x06 -> out_valid=0, pending=0, illegal_count=0 without a clock edge.
